operand_loader_120: RTL and testbench
=====================================

Name: operand_loader_120

Overview:
- Upstream feeder for the 120-bit ripple adder.
- Assembles two 120-bit operands (a, b) and a carry-in from a narrow 16-bit beat stream with valid/ready handshaking.
- Presents the operands as one registered, stable bundle to the adder stage through a valid/ready output handshake.
- Single-buffered; no overlap between loading and presenting.

Parameters:
- DATA_W, 120, operand width; fixed at 120 for this block.
- BEAT_W, 16, input beat width.
- BEATS, 8, beats per operand: ceil(DATA_W/BEAT_W). The final beat carries only DATA_W-7*BEAT_W = 8 valid bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  16  beat payload.
- in_sof  input  1  start-of-frame marker; must be 1 on the first beat of operand a.
- in_cin  input  1  carry-in; sampled on the first accepted beat of operand a.
- op_valid  output  1  operand bundle valid.
- op_ready  input  1  downstream adder stage accepts the bundle.
- op_a  output  120  operand a.
- op_b  output  120  operand b.
- op_cin  output  1  carry-in for the adder.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst high at a clk edge), regardless of state or any handshake in progress:
  - state=LOAD_A, beat_idx=0.
  - op_a=0, op_b=0, op_cin=0, op_valid=0, frame_err=0.
  - A partially loaded frame is discarded.
- in_ready is combinational: 1 in LOAD_A and LOAD_B, 0 in PRESENT. It reads 1 in the first cycle after reset.
- Beat placement:
  - Accepted beat k (k=0..6) writes in_data[15:0] to bits [16k+15:16k] of the current operand.
  - Beat 7 writes in_data[7:0] to bits [119:112]; in_data[15:8] is ignored.
- LOAD_A:
  - Each accepted beat increments beat_idx.
  - Beat 0 also captures in_cin into op_cin.
  - On accepting beat 7: beat_idx<=0, state<=LOAD_B.
- LOAD_B:
  - Same beat placement into op_b.
  - On accepting beat 7: beat_idx<=0, state<=PRESENT, op_valid<=1 (registered, so op_valid rises the cycle after the last beat).
- PRESENT:
  - op_a, op_b and op_cin stay stable while op_valid=1.
  - On op_valid && op_ready: op_valid<=0, state<=LOAD_A.
  - in_ready returns to 1 in the following cycle. Minimum turnaround is 1 idle input cycle per frame.
  - op_ready while op_valid=0 has no effect.
- Framing:
  - Accepted beat with in_sof=1 while not at LOAD_A beat 0: frame_err pulses 1 cycle. The beat is treated as LOAD_A beat 0 (resync): op_a[15:0] and op_cin are written, beat_idx<=1, state<=LOAD_A.
  - Accepted beat at LOAD_A beat 0 with in_sof=0: frame_err pulses, the beat is dropped, and state and beat_idx are unchanged.
- Stalls: in_valid=0 holds all state. Beats are never lost while in_ready=1.
- Output latency: the first beat of a frame reaches the outputs 16 accepted beats plus 1 cycle later.
- Full frame throughput with an always-ready sink: 16 beats + 1 PRESENT cycle = 17 cycles per frame.

Test Plan:
- Reset, then stream 16 beats continuously (a beats 0x0001..0x0008 with sof on the first and in_cin=1; b beats 0x0010..0x0017) -> op_valid rises 1 cycle after the 16th beat. Expected values:
  - op_a = 0x08_0007_0006_0005_0004_0003_0002_0001
  - op_b = 0x17_0016_0015_0014_0013_0012_0011_0010
  - op_cin = 1
- Same frame with op_ready held 0 for 10 cycles -> outputs stable, in_ready=0 throughout; op_valid clears the cycle after op_ready=1.
- Beat 7 of a = 0xABCD -> op_a[119:112]=0xCD; upper byte discarded.
- Assert in_sof on b beat 3 -> frame_err pulses once; state returns to LOAD_A at beat_idx=1; the next 15 beats complete a valid frame.
- Beat without sof at frame start -> frame_err pulses, beat dropped, op_valid stays 0.
- Assert rst mid-LOAD_B and again in PRESENT -> all outputs return to 0, in_ready=1 the next cycle, and a fresh frame then loads correctly.

Source files
------------

// File: rtl/operand_loader_120.sv
// operand_loader_120: assembles two 120-bit operands and a carry-in from a
// 16-bit beat stream and presents them as one registered bundle to the
// 120-bit ripple adder. The block is single-buffered, so loading and
// presenting never overlap.
module operand_loader_120 #(
  parameter int DATA_W = 120,
  parameter int BEAT_W = 16,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_cin,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_cin,
  output logic              frame_err
);

  localparam int IDX_W  = $clog2(BEATS);
  localparam int LAST_W = DATA_W - (BEATS - 1) * BEAT_W;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   beat_idx, beat_idx_n;
  logic [DATA_W-1:0]  op_a_n, op_b_n;
  logic               op_cin_n, op_valid_n, frame_err_n;
  logic               accept;
  logic               at_frame_start;
  logic               last_beat;

  // Merge one beat into an operand; the final beat only carries LAST_W bits.
  function automatic logic [DATA_W-1:0] place_beat(
    input logic [DATA_W-1:0] cur,
    input logic [IDX_W-1:0]  idx,
    input logic [BEAT_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    r = cur;
    for (int unsigned i = 0; i < BEATS - 1; i++) begin
      if (idx == IDX_W'(i)) r[i*BEAT_W +: BEAT_W] = d;
    end
    if (idx == IDX_W'(BEATS - 1)) r[DATA_W-1 -: LAST_W] = d[LAST_W-1:0];
    return r;
  endfunction

  // Next-state, beat placement, framing checks and input handshake.
  always_comb begin
    state_n        = state;
    beat_idx_n     = beat_idx;
    op_a_n         = op_a;
    op_b_n         = op_b;
    op_cin_n       = op_cin;
    op_valid_n     = op_valid;
    frame_err_n    = 1'b0;
    in_ready       = (state != PRESENT);
    accept         = in_valid && (state != PRESENT);
    at_frame_start = (state == LOAD_A) && (beat_idx == '0);
    last_beat      = (beat_idx == IDX_W'(BEATS - 1));

    case (state)
      PRESENT: begin
        if (op_valid && op_ready) begin
          op_valid_n = 1'b0;
          state_n    = LOAD_A;
        end
      end
      default: begin
        if (accept) begin
          if (in_sof && !at_frame_start) begin
            // Stray start-of-frame: restart operand a with this beat as beat 0.
            frame_err_n = 1'b1;
            op_a_n      = place_beat(op_a, '0, in_data);
            op_cin_n    = in_cin;
            beat_idx_n  = IDX_W'(1);
            state_n     = LOAD_A;
          end else if (at_frame_start && !in_sof) begin
            // Missing start-of-frame: drop the beat and keep waiting.
            frame_err_n = 1'b1;
          end else if (state == LOAD_A) begin
            op_a_n = place_beat(op_a, beat_idx, in_data);
            if (beat_idx == '0) op_cin_n = in_cin;
            if (last_beat) begin
              beat_idx_n = '0;
              state_n    = LOAD_B;
            end else begin
              beat_idx_n = beat_idx + IDX_W'(1);
            end
          end else begin
            op_b_n = place_beat(op_b, beat_idx, in_data);
            if (last_beat) begin
              beat_idx_n = '0;
              op_valid_n = 1'b1;
              state_n    = PRESENT;
            end else begin
              beat_idx_n = beat_idx + IDX_W'(1);
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      beat_idx  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      beat_idx  <= beat_idx_n;
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      op_cin    <= op_cin_n;
      op_valid  <= op_valid_n;
      frame_err <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_operand_loader_120.sv
// Directed self-checking bench for operand_loader_120.
module tb_operand_loader_120;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         in_sof;
  logic         in_cin;
  logic         op_valid;
  logic         op_ready;
  logic [119:0] op_a;
  logic [119:0] op_b;
  logic         op_cin;
  logic         frame_err;

  int errors = 0;
  int checks = 0;

  operand_loader_120 #(.DATA_W(120), .BEAT_W(16), .BEATS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_cin    (in_cin),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic s, input logic c);
    chk("in_ready_before_beat", {119'd0, in_ready}, 120'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_cin   = c;
    tick();
  endtask

  // Operand built from beats base+k; the last beat contributes its low byte.
  function automatic logic [119:0] exp_op(input logic [15:0] base);
    logic [119:0] r;
    logic [15:0]  t;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      t = base + 16'(k);
      r[16*k +: 16] = t;
    end
    t = base + 16'd7;
    r[119:112] = t[7:0];
    return r;
  endfunction

  // Full clean frame; carry-in is offered inverted on non-first beats so
  // only beat 0 may capture it.
  task automatic send_frame(input logic [15:0] a_base, input logic [15:0] b_base, input logic c);
    for (int k = 0; k < 8; k++) beat(a_base + 16'(k), (k == 0), (k == 0) ? c : ~c);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("op_valid_before_last", {119'd0, op_valid}, 120'd0);
      beat(b_base + 16'(k), 1'b0, ~c);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic ack();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("op_valid_after_ack", {119'd0, op_valid}, 120'd0);
    chk("in_ready_after_ack", {119'd0, in_ready}, 120'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_cin = 1'b0; op_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_op_valid", {119'd0, op_valid}, 120'd0);
    chk("rst_op_a", op_a, 120'd0);
    chk("rst_op_b", op_b, 120'd0);
    chk("rst_op_cin", {119'd0, op_cin}, 120'd0);
    chk("rst_frame_err", {119'd0, frame_err}, 120'd0);
    chk("rst_in_ready", {119'd0, in_ready}, 120'd1);

    // Basic frame, continuous stream, always-ready sink
    send_frame(16'h0001, 16'h0010, 1'b1);
    chk("t1_op_valid", {119'd0, op_valid}, 120'd1);
    chk("t1_op_a", op_a, 120'h08_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_op_b", op_b, 120'h17_0016_0015_0014_0013_0012_0011_0010);
    chk("t1_op_cin", {119'd0, op_cin}, 120'd1);
    chk("t1_in_ready", {119'd0, in_ready}, 120'd0);
    chk("t1_frame_err", {119'd0, frame_err}, 120'd0);
    ack();

    // Backpressure for 10 cycles; a beat 7 = 0xABCD drops its upper byte
    for (int k = 0; k < 7; k++) beat(16'h0001 + 16'(k), (k == 0), (k != 0));
    beat(16'hABCD, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) beat(16'h0010 + 16'(k), 1'b0, 1'b1);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 16'hFFFF; in_cin = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("t2_hold_op_valid", {119'd0, op_valid}, 120'd1);
      chk("t2_hold_in_ready", {119'd0, in_ready}, 120'd0);
      chk("t2_hold_op_a", op_a, 120'hCD_0007_0006_0005_0004_0003_0002_0001);
      chk("t2_hold_op_b", op_b, 120'h17_0016_0015_0014_0013_0012_0011_0010);
      chk("t2_hold_op_cin", {119'd0, op_cin}, 120'd0);
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    ack();
    chk("t2_no_err", {119'd0, frame_err}, 120'd0);

    // Stray sof on b beat 3 resynchronises to a beat 0
    for (int k = 0; k < 8; k++) beat(16'h0100 + 16'(k), (k == 0), 1'b0);
    for (int k = 0; k < 3; k++) beat(16'h0200 + 16'(k), 1'b0, 1'b0);
    beat(16'h1111, 1'b1, 1'b1);
    chk("t4_frame_err_pulse", {119'd0, frame_err}, 120'd1);
    chk("t4_op_valid_low", {119'd0, op_valid}, 120'd0);
    for (int k = 1; k < 8; k++) begin
      beat(16'hA000 + 16'(k), 1'b0, 1'b0);
      if (k == 1) chk("t4_frame_err_single", {119'd0, frame_err}, 120'd0);
    end
    for (int k = 0; k < 8; k++) beat(16'hB000 + 16'(k), 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("t4_op_valid", {119'd0, op_valid}, 120'd1);
    chk("t4_op_a", op_a, 120'h07_A006_A005_A004_A003_A002_A001_1111);
    chk("t4_op_b", op_b, 120'h07_B006_B005_B004_B003_B002_B001_B000);
    chk("t4_op_cin", {119'd0, op_cin}, 120'd1);
    ack();

    // Missing sof at frame start: beat dropped
    beat(16'h5555, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("t5_frame_err_pulse", {119'd0, frame_err}, 120'd1);
    chk("t5_op_valid_low", {119'd0, op_valid}, 120'd0);
    tick();
    chk("t5_frame_err_clear", {119'd0, frame_err}, 120'd0);
    send_frame(16'h3000, 16'h4000, 1'b1);
    chk("t5_op_valid", {119'd0, op_valid}, 120'd1);
    chk("t5_op_a", op_a, exp_op(16'h3000));
    chk("t5_op_b", op_b, exp_op(16'h4000));
    chk("t5_op_cin", {119'd0, op_cin}, 120'd1);
    ack();

    // Reset mid LOAD_B
    for (int k = 0; k < 8; k++) beat(16'h6000 + 16'(k), (k == 0), 1'b1);
    for (int k = 0; k < 3; k++) beat(16'h6100 + 16'(k), 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6a_op_a", op_a, 120'd0);
    chk("t6a_op_b", op_b, 120'd0);
    chk("t6a_op_cin", {119'd0, op_cin}, 120'd0);
    chk("t6a_op_valid", {119'd0, op_valid}, 120'd0);
    chk("t6a_in_ready", {119'd0, in_ready}, 120'd1);

    // Reset in PRESENT
    send_frame(16'h7000, 16'h7100, 1'b1);
    chk("t6b_op_valid_pre", {119'd0, op_valid}, 120'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6b_op_a", op_a, 120'd0);
    chk("t6b_op_b", op_b, 120'd0);
    chk("t6b_op_cin", {119'd0, op_cin}, 120'd0);
    chk("t6b_op_valid", {119'd0, op_valid}, 120'd0);
    chk("t6b_in_ready", {119'd0, in_ready}, 120'd1);

    // Fresh frame after reset
    send_frame(16'h9000, 16'hC000, 1'b0);
    chk("t6c_op_valid", {119'd0, op_valid}, 120'd1);
    chk("t6c_op_a", op_a, exp_op(16'h9000));
    chk("t6c_op_b", op_b, exp_op(16'hC000));
    chk("t6c_op_cin", {119'd0, op_cin}, 120'd0);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
